memory_bus_initiator: RTL and testbench
=======================================

Name: memory_bus_initiator

Overview:
- Bus master for the memory bus: turns single core-side load/store requests into bus_read_data / bus_write_data packets and returns read data from the matching bus response.
- Sits between a core's load/store unit and the DRAM responder.
- One outstanding transaction; bounds-checks addresses before issue.
- A timeout guards against lost read responses.

Parameters:
- SOURCE_ID, 0, this initiator's bus source tag; placed in every request and matched against response destination.
- MEM_BYTES, 65536, size of backing store in bytes; legal addresses are 0..MEM_BYTES-8.
- TIMEOUT, 1024, cycles to wait for a read response before reporting error; must be >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cpu_req_valid  in  1  core request present
- cpu_req_ready  out  1  initiator can accept request
- cpu_req_write  in  1  1 = store, 0 = load
- cpu_req_addr  in  64  byte address
- cpu_req_wdata  in  64  store data, 8 bytes, little-endian
- cpu_rsp_valid  out  1  one-cycle completion pulse
- cpu_rsp_rdata  out  64  load data; 0 for stores and errors
- cpu_rsp_error  out  1  bounds violation or timeout
- bus_req_valid  out  1  request packet valid
- bus_req_type  out  bus_packet_type_t  bus_read_data or bus_write_data
- bus_req_addr  out  64  packet address
- bus_req_payload  out  64  packet payload; 0 for reads
- bus_req_source  out  bus_source_t  = SOURCE_ID
- bus_req_accept  in  1  responder takes packet this cycle
- bus_rsp_valid  in  1  read response present
- bus_rsp_payload  in  64  read data
- bus_rsp_dest  in  bus_source_t  response destination tag

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0 except cpu_req_ready=1; latched addr/data/type cleared; timeout counter 0.
- Reset asserted mid-transaction abandons it with no cpu_rsp pulse. Any later bus response for the abandoned transaction arrives in IDLE and is ignored.
- States:
  - IDLE: cpu_req_ready=1. On cpu_req_valid, latch write/addr/wdata.
    - If addr > MEM_BYTES-8 (unsigned 64-bit compare): go to RESPOND with error=1; no bus traffic.
    - Else: go to ISSUE.
  - ISSUE: bus_req_valid=1 with latched fields; fields stay stable until bus_req_accept.
    - On accept, write: go to RESPOND (writes are posted; error=0, rdata=0).
    - On accept, read: go to WAIT_RSP with counter=0.
    - bus_rsp_valid in ISSUE is ignored.
  - WAIT_RSP: counter increments each cycle.
    - bus_rsp_valid && bus_rsp_dest==SOURCE_ID: latch payload into rdata, go to RESPOND.
    - Response with any other dest is ignored.
    - Counter == TIMEOUT-1 with no match: go to RESPOND, error=1, rdata=0.
    - A match in the same cycle as the timeout wins, giving data with error=0.
  - RESPOND: cpu_rsp_valid=1 for exactly one cycle with rdata/error; next state IDLE.
- cpu_req_ready=0 in every state except IDLE; cpu_req_valid outside IDLE is ignored.
- Latency in cycles:
  - Store: accept in IDLE → ISSUE → (accept) → RESPOND. Minimum 3 cycles from request to cpu_rsp_valid.
  - Load: minimum 4 cycles (response arriving the cycle after accept).
  - Bounds error: 2 cycles.
- Back-to-back: a new request can be accepted in the IDLE cycle following RESPOND.
- Outputs are registered, driven from state and latched fields only; no combinational paths from bus inputs to core outputs.

Decomposition:
- Shared package: bus_packet_type_t (bus_write_data, bus_read_data), bus_source_t, bus_packet_payload_t (64-bit), END_MEMORY_ADDRESS/MEM_BYTES default, initiator state enum.
- Sub-module: bus_timeout_counter, a clear/enable counter with terminal-count flag, width $clog2(TIMEOUT).

Test Plan:
- Store addr=0x100, wdata=0x1122334455667788, accept held low 3 cycles → bus_req_valid with stable fields for 4 cycles, write packet with source=SOURCE_ID; cpu_rsp_valid one cycle later, error=0, rdata=0.
- Load addr=0x100, response dest=SOURCE_ID payload=0xDEADBEEFCAFEF00D 5 cycles after accept → cpu_rsp_rdata=0xDEADBEEFCAFEF00D, error=0; exactly one rsp pulse.
- Load with a response for dest=SOURCE_ID+1 first, then the matching response → foreign response ignored; only matching payload returned.
- Load addr=MEM_BYTES-7 → no bus_req_valid ever; cpu_rsp_valid after 2 cycles, error=1.
- Load accepted, no response (TIMEOUT=16) → rsp error=1, rdata=0 exactly 16 cycles after accept; a late response afterwards is ignored in IDLE.
- Reset pulse while in WAIT_RSP → outputs zero immediately (async), cpu_req_ready=1 after release; a subsequent store completes normally.

Source files
------------

// File: rtl/memory_bus_initiator_pkg.sv
// Shared types for the memory-bus initiator: packet type, source tag,
// payload word, address-map defaults and the initiator state encoding.
package memory_bus_initiator_pkg;

  typedef enum logic {
    bus_write_data = 1'b0,
    bus_read_data  = 1'b1
  } bus_packet_type_t;

  typedef logic [7:0]  bus_source_t;
  typedef logic [63:0] bus_packet_payload_t;

  localparam int MEM_BYTES_DEFAULT  = 65536;
  localparam int END_MEMORY_ADDRESS = MEM_BYTES_DEFAULT - 8;
  localparam int TIMEOUT_DEFAULT    = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_RESPOND
  } init_state_t;

  // A full 8-byte access must fit below mem_bytes.
  function automatic logic addr_in_bounds(
    input logic [63:0] addr,
    input int          mem_bytes
  );
    return addr <= (64'(mem_bytes) - 64'd8);
  endfunction

endpackage

// File: rtl/memory_bus_initiator_timeout.sv
// bus_timeout_counter: clearable/enabled up-counter whose terminal flag
// marks the last cycle of a TIMEOUT-cycle window.
// Ports: clk, reset, clear, enable in; terminal out.
module bus_timeout_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/memory_bus_initiator.sv
// Memory-bus initiator: one outstanding load/store, bounds check,
// read-response timeout. Core side: cpu_req_* in, cpu_rsp_* out.
// Bus side: bus_req_* out (accept in), bus_rsp_* in.
module memory_bus_initiator
  import memory_bus_initiator_pkg::*;
#(
  parameter bus_source_t SOURCE_ID = '0,
  parameter int          MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int          TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_write,
  input  logic [63:0]         cpu_req_addr,
  input  logic [63:0]         cpu_req_wdata,
  output logic                cpu_rsp_valid,
  output logic [63:0]         cpu_rsp_rdata,
  output logic                cpu_rsp_error,
  output logic                bus_req_valid,
  output bus_packet_type_t    bus_req_type,
  output logic [63:0]         bus_req_addr,
  output bus_packet_payload_t bus_req_payload,
  output bus_source_t         bus_req_source,
  input  logic                bus_req_accept,
  input  logic                bus_rsp_valid,
  input  bus_packet_payload_t bus_rsp_payload,
  input  bus_source_t         bus_rsp_dest
);

  init_state_t state_q, state_d;

  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        error_q;

  logic in_wait;
  logic tmo_term;
  logic rsp_match;
  logic timeout_hit;
  logic req_ok;

  assign in_wait     = (state_q == ST_WAIT_RSP);
  assign rsp_match   = in_wait && bus_rsp_valid
                       && (bus_rsp_dest == SOURCE_ID);
  assign timeout_hit = in_wait && tmo_term;
  assign req_ok      = addr_in_bounds(cpu_req_addr, MEM_BYTES);

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_wait),
    .enable   (in_wait),
    .terminal (tmo_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_valid) begin
          state_d = req_ok ? ST_ISSUE : ST_RESPOND;
        end
      end
      ST_ISSUE: begin
        if (bus_req_accept) begin
          state_d = write_q ? ST_RESPOND : ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_match || timeout_hit) begin
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Latched request fields and completion result.
  // A response match takes priority over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_req_valid) begin
            write_q <= cpu_req_write;
            addr_q  <= cpu_req_addr;
            wdata_q <= cpu_req_wdata;
            rdata_q <= '0;
            error_q <= !req_ok;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_match) begin
            rdata_q <= bus_rsp_payload;
            error_q <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs depend only on state and latched registers.
  always_comb begin
    cpu_req_ready   = 1'b0;
    cpu_rsp_valid   = 1'b0;
    cpu_rsp_rdata   = '0;
    cpu_rsp_error   = 1'b0;
    bus_req_valid   = 1'b0;
    bus_req_type    = bus_write_data;
    bus_req_addr    = '0;
    bus_req_payload = '0;
    bus_req_source  = '0;
    case (state_q)
      ST_IDLE: cpu_req_ready = 1'b1;
      ST_ISSUE: begin
        bus_req_valid   = 1'b1;
        bus_req_type    = write_q ? bus_write_data
                                  : bus_read_data;
        bus_req_addr    = addr_q;
        bus_req_payload = write_q ? wdata_q : '0;
        bus_req_source  = SOURCE_ID;
      end
      ST_RESPOND: begin
        cpu_rsp_valid = 1'b1;
        cpu_rsp_rdata = rdata_q;
        cpu_rsp_error = error_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_bus_initiator.sv
// Testbench for memory_bus_initiator: table vectors, reset abort
// sequence and random transactions against a latency/result model.
`timescale 1ns/1ps
module tb_memory_bus_initiator;
  import memory_bus_initiator_pkg::*;

  localparam bus_source_t SRC = 8'd5;
  localparam int MEMB = 65536;
  localparam int TMO  = 16;
  localparam logic [63:0] LAST_OK = 64'(MEMB - 8);

  logic                clk = 1'b0;
  logic                reset;
  logic                cpu_req_valid;
  logic                cpu_req_ready;
  logic                cpu_req_write;
  logic [63:0]         cpu_req_addr;
  logic [63:0]         cpu_req_wdata;
  logic                cpu_rsp_valid;
  logic [63:0]         cpu_rsp_rdata;
  logic                cpu_rsp_error;
  logic                bus_req_valid;
  bus_packet_type_t    bus_req_type;
  logic [63:0]         bus_req_addr;
  bus_packet_payload_t bus_req_payload;
  bus_source_t         bus_req_source;
  logic                bus_req_accept;
  logic                bus_rsp_valid;
  bus_packet_payload_t bus_rsp_payload;
  bus_source_t         bus_rsp_dest;

  always #5 clk = ~clk;

  memory_bus_initiator #(
    .SOURCE_ID (SRC),
    .MEM_BYTES (MEMB),
    .TIMEOUT   (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_req_write   (cpu_req_write),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_req_wdata   (cpu_req_wdata),
    .cpu_rsp_valid   (cpu_rsp_valid),
    .cpu_rsp_rdata   (cpu_rsp_rdata),
    .cpu_rsp_error   (cpu_rsp_error),
    .bus_req_valid   (bus_req_valid),
    .bus_req_type    (bus_req_type),
    .bus_req_addr    (bus_req_addr),
    .bus_req_payload (bus_req_payload),
    .bus_req_source  (bus_req_source),
    .bus_req_accept  (bus_req_accept),
    .bus_rsp_valid   (bus_rsp_valid),
    .bus_rsp_payload (bus_rsp_payload),
    .bus_rsp_dest    (bus_rsp_dest)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          latency;
    int          pulses;
    int          issue;
    logic [63:0] rdata;
    logic        err;
    bit          pkt_bad;
    bit          rdy_bad;
    bit          rdy_after;
  } obs_t;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          acc;
    int          rsp;
    logic [63:0] pay;
    bit          foreign;
    logic        exp_err;
    logic [63:0] exp_rdata;
    int          exp_lat;
    int          exp_issue;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h",
               name, got, exp);
    end
  endtask

  // Result from the rules: bounds error in 2 cycles, posted store
  // after accept, load answered within TMO wait cycles else error.
  function automatic void model(
    input  logic        wr,
    input  logic [63:0] addr,
    input  int          acc,
    input  int          rsp,
    input  logic [63:0] pay,
    output logic        err,
    output logic [63:0] rd,
    output int          lat,
    output int          iss);
    if (addr > LAST_OK) begin
      err = 1; rd = 0; lat = 2; iss = 0;
    end else if (wr) begin
      err = 0; rd = 0; lat = 3 + acc; iss = acc + 1;
    end else if (rsp <= TMO) begin
      err = 0; rd = pay; lat = 3 + acc + rsp; iss = acc + 1;
    end else begin
      err = 1; rd = 0; lat = 3 + acc + TMO; iss = acc + 1;
    end
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic run_txn(input logic wr,
                         input logic [63:0] addr,
                         input logic [63:0] wdata,
                         input int acc,
                         input int rsp,
                         input logic [63:0] pay,
                         input bit foreign,
                         output obs_t o);
    int acc_cyc = -1;
    int rsp_cyc = -1;
    bit done;
    bus_packet_type_t et;
    logic [63:0] ep;
    et = wr ? bus_write_data : bus_read_data;
    ep = wr ? wdata : 64'd0;
    o.latency = -1; o.pulses = 0; o.issue = 0;
    o.rdata = 0; o.err = 0;
    o.pkt_bad = 0; o.rdy_bad = 0; o.rdy_after = 0;
    cpu_req_valid = 1; cpu_req_write = wr;
    cpu_req_addr = addr; cpu_req_wdata = wdata;
    for (int c = 0; c < 150; c++) begin
      if (c > 0) begin
        cpu_req_valid = 0;
        cpu_req_write = 1'($urandom);
        cpu_req_addr  = {$urandom, $urandom};
        cpu_req_wdata = {$urandom, $urandom};
      end
      if (cpu_rsp_valid) begin
        o.pulses++;
        if (o.pulses == 1) begin
          rsp_cyc = c; o.latency = c + 1;
          o.rdata = cpu_rsp_rdata; o.err = cpu_rsp_error;
        end
      end
      if (c == 0 && !cpu_req_ready) o.rdy_bad = 1;
      if (c > 0 && (rsp_cyc < 0 || c == rsp_cyc)
          && cpu_req_ready) o.rdy_bad = 1;
      if (rsp_cyc >= 0 && c == rsp_cyc + 1)
        o.rdy_after = cpu_req_ready;
      bus_req_accept = 0;
      if (bus_req_valid) begin
        o.issue++;
        if (bus_req_type !== et || bus_req_addr !== addr ||
            bus_req_payload !== ep || bus_req_source !== SRC)
          o.pkt_bad = 1;
        if (o.issue == acc + 1) begin
          bus_req_accept = 1; acc_cyc = c;
        end
      end
      bus_rsp_valid = 0; bus_rsp_dest = SRC;
      bus_rsp_payload = {$urandom, $urandom};
      if (!wr && acc_cyc < 0 && bus_req_valid) begin
        bus_rsp_valid = 1;
      end else if (!wr && acc_cyc >= 0 && c == acc_cyc + rsp) begin
        bus_rsp_valid = 1; bus_rsp_payload = pay;
      end else if (!wr && foreign && acc_cyc >= 0 &&
                   c == acc_cyc + rsp - 1) begin
        bus_rsp_valid = 1; bus_rsp_dest = SRC + 8'd1;
        bus_rsp_payload = ~pay;
      end
      done = rsp_cyc >= 0 && c >= rsp_cyc + 3 &&
             (wr || acc_cyc < 0 || c > acc_cyc + rsp);
      @(negedge clk);
      if (done) break;
    end
    bus_req_accept = 0; bus_rsp_valid = 0;
  endtask

  task automatic compare(input string tag, input obs_t o,
                         input logic ee, input logic [63:0] er,
                         input int el, input int ei);
    chk({tag, ".latency"}, 64'(o.latency), 64'(el));
    chk({tag, ".rdata"}, o.rdata, er);
    chk({tag, ".error"}, 64'(o.err), 64'(ee));
    chk({tag, ".pulses"}, 64'(o.pulses), 64'd1);
    chk({tag, ".issue_cycles"}, 64'(o.issue), 64'(ei));
    chk({tag, ".packet"}, 64'(o.pkt_bad), 64'd0);
    chk({tag, ".ready_busy"}, 64'(o.rdy_bad), 64'd0);
    chk({tag, ".ready_after"}, 64'(o.rdy_after), 64'd1);
  endtask

  vec_t tbl[10];

  initial begin
    obs_t o;
    logic        m_err;
    logic [63:0] m_rd;
    int          m_lat, m_iss, pulses;
    logic        wr;
    logic [63:0] addr, wd, pay;
    int          acc, rsp;
    bit          frn;

    tbl[0] = '{1'b1, 64'h100, 64'h1122334455667788, 3, 1,
               64'h0, 1'b0, 1'b0, 64'h0, 6, 4};
    tbl[1] = '{1'b0, 64'h100, 64'h0, 0, 5,
               64'hDEADBEEFCAFEF00D, 1'b0, 1'b0,
               64'hDEADBEEFCAFEF00D, 8, 1};
    tbl[2] = '{1'b0, 64'h180, 64'h0, 1, 4,
               64'h0123456789ABCDEF, 1'b1, 1'b0,
               64'h0123456789ABCDEF, 8, 2};
    tbl[3] = '{1'b0, 64'd65529, 64'h0, 0, 1,
               64'h55, 1'b0, 1'b1, 64'h0, 2, 0};
    tbl[4] = '{1'b0, 64'h200, 64'h0, 0, 40,
               64'h77, 1'b0, 1'b1, 64'h0, 19, 1};
    tbl[5] = '{1'b0, 64'h208, 64'h0, 2, 16,
               64'hA5A5A5A55A5A5A5A, 1'b1, 1'b0,
               64'hA5A5A5A55A5A5A5A, 21, 3};
    tbl[6] = '{1'b1, 64'd65528, 64'hCAFE, 0, 1,
               64'h0, 1'b0, 1'b0, 64'h0, 3, 1};
    tbl[7] = '{1'b1, 64'hFFFFFFFFFFFFFFF8, 64'h1, 0, 1,
               64'h0, 1'b0, 1'b1, 64'h0, 2, 0};
    tbl[8] = '{1'b0, 64'h8, 64'h0, 0, 1,
               64'h0000000012345678, 1'b0, 1'b0,
               64'h0000000012345678, 4, 1};
    tbl[9] = '{1'b0, 64'h10, 64'h0, 0, 17,
               64'h99, 1'b0, 1'b1, 64'h0, 19, 1};

    reset = 0; cpu_req_valid = 0; cpu_req_write = 0;
    cpu_req_addr = 0; cpu_req_wdata = 0; bus_req_accept = 0;
    bus_rsp_valid = 0; bus_rsp_payload = 0; bus_rsp_dest = 0;
    #1 reset = 1;
    #2;
    chk("reset.ready", 64'(cpu_req_ready), 64'd1);
    chk("reset.rsp_valid", 64'(cpu_rsp_valid), 64'd0);
    chk("reset.rsp_rdata", cpu_rsp_rdata, 64'd0);
    chk("reset.bus_valid", 64'(bus_req_valid), 64'd0);
    chk("reset.bus_source", 64'(bus_req_source), 64'd0);
    chk("reset.bus_payload", bus_req_payload, 64'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata,
              tbl[i].acc, tbl[i].rsp, tbl[i].pay,
              tbl[i].foreign, o);
      compare($sformatf("vec%0d", i), o, tbl[i].exp_err,
              tbl[i].exp_rdata, tbl[i].exp_lat, tbl[i].exp_issue);
    end

    // Reset while waiting for a read response.
    cpu_req_valid = 1; cpu_req_write = 0;
    cpu_req_addr = 64'h300; cpu_req_wdata = 0;
    @(negedge clk);
    cpu_req_valid = 0;
    chk("abort.issue_valid", 64'(bus_req_valid), 64'd1);
    bus_req_accept = 1;
    @(negedge clk);
    bus_req_accept = 0;
    repeat (3) @(negedge clk);
    chk("abort.wait_ready", 64'(cpu_req_ready), 64'd0);
    #2 reset = 1;
    #1;
    chk("abort.async_ready", 64'(cpu_req_ready), 64'd1);
    chk("abort.async_rsp", 64'(cpu_rsp_valid), 64'd0);
    chk("abort.async_bus", 64'(bus_req_valid), 64'd0);
    @(negedge clk);
    reset = 0;
    pulses = 0;
    bus_rsp_valid = 1; bus_rsp_dest = SRC;
    bus_rsp_payload = 64'hBAD0BAD0BAD0BAD0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus_rsp_valid = 0;
      if (cpu_rsp_valid || bus_req_valid) pulses++;
    end
    chk("abort.late_rsp_ignored", 64'(pulses), 64'd0);
    chk("abort.ready_after", 64'(cpu_req_ready), 64'd1);
    run_txn(1'b1, 64'h400, 64'h0F0E0D0C0B0A0908, 1, 1,
            64'h0, 1'b0, o);
    compare("abort.store", o, 1'b0, 64'h0, 4, 2);

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom);
      case ($urandom_range(0, 3))
        0: addr = 64'($urandom_range(0, MEMB - 8));
        1: addr = LAST_OK;
        2: addr = LAST_OK + 64'($urandom_range(1, 16));
        default: addr = {$urandom, $urandom};
      endcase
      wd  = {$urandom, $urandom};
      pay = {$urandom, $urandom};
      acc = $urandom_range(0, 4);
      rsp = $urandom_range(1, 20);
      frn = 1'($urandom);
      model(wr, addr, acc, rsp, pay, m_err, m_rd, m_lat, m_iss);
      run_txn(wr, addr, wd, acc, rsp, pay, frn, o);
      compare($sformatf("rnd%0d", n), o, m_err, m_rd,
              m_lat, m_iss);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
